// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO arbiter/controller slice.
package fifo_arb_pkg;

  // Number of requesters sharing the FIFO and their bit positions in request vectors
  localparam int NUM_REQ = 3;
  localparam int REQ_WR0 = 0;
  localparam int REQ_WR1 = 1;
  localparam int REQ_RD  = 2;

  // Controller states: one FIFO operation walks IDLE -> STB -> REL -> DONE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STB   = 3'd1,
    REL   = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  // Which requester owns the operation in flight (also the round-robin pointer)
  typedef enum logic [1:0] {
    G_WR0 = 2'd0,
    G_WR1 = 2'd1,
    G_RD  = 2'd2
  } grant_t;

  // The FIFO status flags are active-low: TRUE means "the condition holds"
  localparam logic TRUE  = 1'b0;
  localparam logic FALSE = 1'b1;

  // Convert a one-hot arbiter grant into the encoded grant
  function automatic grant_t onehot_to_grant(input logic [NUM_REQ-1:0] oh);
    grant_t g;
    g = G_WR0;
    if (oh[REQ_WR1]) g = G_WR1;
    if (oh[REQ_RD])  g = G_RD;
    return g;
  endfunction

  // Requesters that come after 'last' in the wr0 -> wr1 -> rd order (no wrap)
  function automatic logic [NUM_REQ-1:0] after_last(input grant_t last);
    logic [NUM_REQ-1:0] mask;
    case (last)
      G_WR0:   mask = 3'b110;
      G_WR1:   mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/fifo_rr_arb3.sv
// Three-way round-robin arbiter: the requester after the last one served wins first.
module fifo_rr_arb3
  import fifo_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  grant_t             last,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick_src;

  // Look only past the last winner first; if nobody is there, wrap to the lowest index
  always_comb begin
    masked   = eligible & after_last(last);
    pick_src = (masked != '0) ? masked : eligible;
    grant    = pick_src & (~pick_src + NUM_REQ'(1));
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Shares one fifo_mxn between two writers and one reader, one operation per 4 cycles.
module fifo_arb_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 4
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr0_req,
  input  logic [dw-1:0] wr0_dat,
  output logic          wr0_ack,
  input  logic          wr1_req,
  input  logic [dw-1:0] wr1_dat,
  output logic          wr1_ack,
  input  logic          rd_req,
  output logic [dw-1:0] rd_dat,
  output logic          rd_vld,
  output logic          busy,
  output logic          fifo_rst_n,
  output logic          fifo_ien,
  output logic          fifo_oen,
  output logic [dw-1:0] fifo_idat,
  input  logic [dw-1:0] fifo_odat,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic [aw-1:0] fifo_level
);

  state_t             state, state_nxt;
  grant_t             grant, grant_nxt;
  grant_t             last, last_nxt;
  logic [dw-1:0]      idat_nxt;
  logic               ien_nxt;
  logic               oen_nxt;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_grant;

  // Who may be served right now; the FIFO flags are active-low
  always_comb begin
    eligible          = '0;
    eligible[REQ_WR0] = wr0_req & (fifo_full  == FALSE);
    eligible[REQ_WR1] = wr1_req & (fifo_full  == FALSE);
    eligible[REQ_RD]  = rd_req  & (fifo_empty == FALSE);
  end

  fifo_rr_arb3 u_arb (
    .eligible (eligible),
    .last     (last),
    .grant    (arb_grant)
  );

  // Next state, grant latch and strobe levels; flush overrides everything
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    idat_nxt  = fifo_idat;
    ien_nxt   = 1'b0;
    oen_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (arb_grant != '0) begin
          grant_nxt = onehot_to_grant(arb_grant);
          last_nxt  = onehot_to_grant(arb_grant);
          if (arb_grant[REQ_WR1]) begin
            idat_nxt = wr1_dat;
          end else if (arb_grant[REQ_WR0]) begin
            idat_nxt = wr0_dat;
          end
          ien_nxt   = arb_grant[REQ_WR0] | arb_grant[REQ_WR1];
          oen_nxt   = arb_grant[REQ_RD];
          state_nxt = STB;
        end
      end
      STB:     state_nxt = REL;
      REL:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (flush) begin
      state_nxt = FLUSH;
      grant_nxt = grant;
      last_nxt  = last;
      idat_nxt  = fifo_idat;
      ien_nxt   = 1'b0;
      oen_nxt   = 1'b0;
    end
  end

  // State, grant, pointer and registered FIFO strobes; wr0 gets first service after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= G_WR0;
      last      <= G_RD;
      fifo_idat <= '0;
      fifo_ien  <= 1'b0;
      fifo_oen  <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      fifo_idat <= idat_nxt;
      fifo_ien  <= ien_nxt;
      fifo_oen  <= oen_nxt;
    end
  end

  // Completion pulses and FIFO reset; the FIFO has already committed the operation in DONE
  always_comb begin
    busy       = (state != IDLE);
    fifo_rst_n = ~(rst | (state == FLUSH));
    wr0_ack    = (state == DONE) && (grant == G_WR0);
    wr1_ack    = (state == DONE) && (grant == G_WR1);
    rd_vld     = (state == DONE) && (grant == G_RD);
    rd_dat     = rd_vld ? fifo_odat : '0;
  end

  // The level is only watched: an empty FIFO must report zero entries
  assert property (@(posedge clk) disable iff (rst)
                   (fifo_empty == TRUE) |-> (fifo_level == '0));

endmodule

// File: doc/fifo_arb_ctrl.md
Name: fifo_arb_ctrl

Overview:
- Scheduler and configurator for one fifo_mxn instance in the SDIO/SPI bridge.
- Shares the FIFO between two writers (wr0 = SDIO side, wr1 = SPI side) and one reader, using round-robin arbitration.
- Generates the FIFO's falling-edge ien/oen strobes and drives its active-low reset, including a software flush.
- Serialises one FIFO operation at a time, at a fixed 4-cycle cadence.

Parameters:
- dw, 8: data width; must match the FIFO instance.
- aw, 4: FIFO address width; usable capacity is 2^aw-1 entries (15).

Ports:
- clk  in  1: single clock; shared with the FIFO.
- rst  in  1: synchronous, active-high reset.
- flush  in  1: one-cycle request to empty the FIFO.
- wr0_req  in  1: writer 0 request; hold with data stable until wr0_ack.
- wr0_dat  in  dw: writer 0 data.
- wr0_ack  out  1: one-cycle pulse; word pushed.
- wr1_req, wr1_dat, wr1_ack: same as writer 0, for writer 1.
- rd_req  in  1: reader request; hold until rd_vld.
- rd_dat  out  dw: popped word; valid only while rd_vld=1.
- rd_vld  out  1: one-cycle pulse.
- busy  out  1: high whenever state != IDLE.
- fifo_rst_n  out  1: to FIFO rst (async, active-low).
- fifo_ien  out  1: to FIFO ien.
- fifo_oen  out  1: to FIFO oen.
- fifo_idat  out  dw: to FIFO idat.
- fifo_odat  in  dw: from FIFO odat.
- fifo_full  in  1: FIFO full flag; 0 = full.
- fifo_empty  in  1: FIFO empty flag; 0 = empty.
- fifo_level  in  aw: FIFO level; observed only, passes through to nothing.

Behaviour:
- Reset values: state=IDLE, all outputs 0 except fifo_rst_n. rr pointer "last served" = rd, so wr0 has first priority.
- fifo_rst_n = ~(rst | state==FLUSH), combinational. The FIFO is held in reset during rst, which clears its edge buffers and pointers.
- States: IDLE -> STB -> REL -> DONE -> IDLE; FLUSH -> IDLE.
  - fifo_ien/fifo_oen are registered. The selected strobe is 1 in STB only and 0 in all other states.
  - The 1->0 transition entering REL is the FIFO's negedge. The FIFO commits the push/pop at the edge ending REL.
- Eligibility, sampled in IDLE only:
  - wrN eligible: wrN_req & (fifo_full==1).
  - rd eligible: rd_req & (fifo_empty==1).
- Arbitration: round-robin, order wr0 -> wr1 -> rd. The search starts after the last served requester.
  - If a requester wins, latch grant, set fifo_idat <= winner's wrN_dat, update the pointer, and go to STB.
  - If none is eligible, stay in IDLE; requests stay pending with no ack.
- DONE:
  - Write grant: wrN_ack=1 for exactly this cycle.
  - Read grant: rd_vld=1 and rd_dat=fifo_odat, which the FIFO registered at the end of REL. rd_dat is 0 when rd_vld=0.
  - FIFO flags are already updated in DONE.
- Latency: grant cycle t → ack/vld in cycle t+3. Maximum throughput is one operation per 4 cycles.
- Flush: flush=1 in any state → next state FLUSH, overriding arbitration and aborting any in-flight operation.
  - No ack/vld is issued for an aborted operation.
  - fifo_ien/fifo_oen are forced to 0.
  - FLUSH lasts 1 cycle, then IDLE. The rr pointer is unchanged.
- rst mid-operation: same abort semantics as flush. The FIFO is cleared via fifo_rst_n, so any negedge created by the abort is masked.
- Simultaneous flush and rst: rst wins; the result is identical.
- A requester that drops req before its ack is a protocol violation. The grant still completes.
- fifo_level is observed only. Capacity boundary: after 15 pushes fifo_full=0, and further writes are not granted.

Decomposition:
- Package fifo_arb_pkg:
  - state encoding localparams (IDLE, STB, REL, DONE, FLUSH);
  - grant encoding (G_WR0, G_WR1, G_RD);
  - FIFO flag polarity constants TRUE=1'b0, FALSE=1'b1.
- Sub-module fifo_rr_arb3:
  - 3-way round-robin arbiter;
  - inputs: 3-bit eligible vector, last-grant pointer;
  - output: one-hot grant (combinational).

Test Plan:
- Single write: wr0_req=1, wr0_dat=8'hA5 at cycle 0 → fifo_ien=1 in cycle 1 only, wr0_ack in cycle 3, fifo_empty=1 in cycle 3, fifo_level=1 by cycle 4.
- Round-robin: wr0, wr1 and rd requested together with the FIFO holding 1 word → grant order wr0, wr1, rd. Acks/vld land in cycles 3, 7, 11; rd_dat = the oldest word.
- Full boundary: 15 writes of 8'h01..8'h0F → fifo_full=0. A 16th wr1_req receives no ack. After one read, rd_dat=8'h01, the 16th write is granted, and fifo_level returns to 15.
- Empty boundary: rd_req on an empty FIFO → no fifo_oen pulse and no rd_vld for 20 cycles. A wr0 write then completes, and the read completes 4 cycles later with the written data.
- Flush mid-write: flush asserted in the REL cycle → FLUSH the next cycle with fifo_rst_n=0, no wr0_ack. Then fifo_empty=0, fifo_level=0, and the controller is back in IDLE.
- Sync reset: rst=1 for 1 cycle during STB → all outputs 0, fifo_rst_n=0 in that cycle. The next request is granted wr0-first.
